// File: rtl/eql_resp_pkg.sv
// Shared types for the eql_responder slice:
// FSM state encoding and cc_mux compare-select codes.
package eql_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HIT   = 2'b10
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_AB   = 2'b01;
  localparam logic [1:0] SEL_AC   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

endpackage

// File: rtl/eql_responder_edge_det.sv
// Registered change / rising-edge detector.
// RISE=0 flags any change of d_i, RISE=1 flags 0->1 bits.
module edge_det #(
  parameter int W    = 1,
  parameter bit RISE = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic         edge_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= d_i;
  end

  if (RISE) begin : g_rise
    assign edge_o = |(d_i & ~prev_q);
  end else begin : g_chg
    assign edge_o = (d_i != prev_q);
  end

endmodule

// File: rtl/eql_responder.sv
// Compare/count responder for the interrupt handler.
// Define EQL_RESP_TIMEOUT_EN to build the ackout-low watchdog.
module eql_responder
  import eql_resp_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter logic [7:0] LIMIT   = 8'd15,
  parameter logic [7:0] TIMEOUT = 8'd16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       cc_mux,
  input  logic [1:0]       uscite,
  input  logic             enable_count,
  input  logic             ackout,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  output logic             eql,
  output logic             cont_eql,
  output logic [1:0]       code,
  output logic             code_valid,
  output logic [7:0]       ack_count,
  output logic             busy,
  output logic             timeout
);

  state_t     state_q;
  logic [7:0] count_q;
  logic       cont_q;
  logic       eql_q;
  logic [1:0] code_q;
  logic       cv_q;
  logic [7:0] ack_q;
  logic       usc_chg;
  logic       ack_rise;

  edge_det #(.W(2), .RISE(1'b0)) u_usc (
    .clk_i  (clock),
    .rst_i  (reset),
    .d_i    (uscite),
    .edge_o (usc_chg)
  );

  edge_det #(.W(1), .RISE(1'b1)) u_ack (
    .clk_i  (clock),
    .rst_i  (reset),
    .d_i    (ackout),
    .edge_o (ack_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eql_q <= 1'b0;
    end else begin
      unique case (cc_mux)
        SEL_ZERO: eql_q <= 1'b0;
        SEL_AB:   eql_q <= (data_a == data_b);
        SEL_AC:   eql_q <= (data_a == data_c);
        SEL_HOLD: eql_q <= eql_q;
      endcase
    end
  end

  // ">=" also catches a count parked at LIMIT-1 in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      cont_q  <= 1'b0;
    end else begin
      cont_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable_count) begin
            if (count_q >= LIMIT - 8'd1) begin
              count_q <= LIMIT;
              cont_q  <= 1'b1;
              state_q <= HIT;
            end else begin
              count_q <= count_q + 8'd1;
              state_q <= COUNT;
            end
          end
        end
        COUNT: begin
          if (!enable_count) begin
            state_q <= IDLE;
          end else if (count_q >= LIMIT - 8'd1) begin
            count_q <= LIMIT;
            cont_q  <= 1'b1;
            state_q <= HIT;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        HIT: begin
          count_q <= 8'd0;
          state_q <= IDLE;
        end
        default: begin
          count_q <= 8'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q <= 2'b00;
      cv_q   <= 1'b0;
      ack_q  <= 8'd0;
    end else begin
      cv_q <= usc_chg;
      if (usc_chg) code_q <= uscite;
      if (ack_rise && ack_q != 8'hFF) ack_q <= ack_q + 8'd1;
    end
  end

`ifdef EQL_RESP_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic [7:0] wdog_d;
  logic       tmo_q;

  always_comb begin
    wdog_d = 8'd0;
    if (!ackout && enable_count)
      wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q <= 8'd0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (wdog_d >= TIMEOUT) tmo_q <= 1'b1;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign eql        = eql_q;
  assign cont_eql   = cont_q;
  assign code       = code_q;
  assign code_valid = cv_q;
  assign ack_count  = ack_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eql_responder.sv
// Scoreboard bench for eql_responder (default parameters).
// Expectations are queued with a due cycle and checked 1ns after each edge.
module tb_eql_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cc_mux = 2'b00;
  logic [1:0] uscite = 2'b00;
  logic       enable_count = 1'b0;
  logic       ackout = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic [7:0] data_c = 8'h00;
  logic       eql, cont_eql, code_valid, busy, timeout;
  logic [1:0] code;
  logic [7:0] ack_count;

  eql_responder dut (
    .clock        (clock),
    .reset        (reset),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .enable_count (enable_count),
    .ackout       (ackout),
    .data_a       (data_a),
    .data_b       (data_b),
    .data_c       (data_c),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .code         (code),
    .code_valid   (code_valid),
    .ack_count    (ack_count),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  localparam int S_EQL = 0, S_CONT = 1, S_CODE = 2, S_CV = 3;
  localparam int S_ACK = 4, S_BUSY = 5, S_TMO = 6;

  typedef struct {
    int         due;
    string      tag;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs(int sig);
    case (sig)
      S_EQL:   return {7'd0, eql};
      S_CONT:  return {7'd0, cont_eql};
      S_CODE:  return {6'd0, code};
      S_CV:    return {7'd0, code_valid};
      S_ACK:   return ack_count;
      S_BUSY:  return {7'd0, busy};
      default: return {7'd0, timeout};
    endcase
  endfunction

  task automatic push(int lat, string tag, int sig, logic [7:0] v);
    exp_t e;
    e.due = cyc + lat;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t keep[$];
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) chk(sb[i].tag, obs(sb[i].sig), sb[i].val);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    drain();
  endtask

  task automatic push_all_reset(string tag);
    push(0, {tag, "_eql"}, S_EQL, 8'd0);
    push(0, {tag, "_cont"}, S_CONT, 8'd0);
    push(0, {tag, "_code"}, S_CODE, 8'd0);
    push(0, {tag, "_cv"}, S_CV, 8'd0);
    push(0, {tag, "_ack"}, S_ACK, 8'd0);
    push(0, {tag, "_busy"}, S_BUSY, 8'd0);
    push(0, {tag, "_tmo"}, S_TMO, 8'd0);
  endtask

  initial begin
    tick();
    tick();
    push_all_reset("rst");
    drain();
    reset = 1'b0;
    push(1, "cv_post_rst", S_CV, 8'd0);
    tick();

    cc_mux = 2'b01; data_a = 8'h5A; data_b = 8'h5A;
    push(1, "eq_ab", S_EQL, 8'd1); tick();
    data_b = 8'h5B;
    push(1, "neq_ab", S_EQL, 8'd0); tick();
    cc_mux = 2'b10; data_c = 8'h5A;
    push(1, "eq_ac", S_EQL, 8'd1); tick();
    cc_mux = 2'b00;
    push(1, "zero_sel", S_EQL, 8'd0); tick();
    cc_mux = 2'b01; data_b = 8'h5A;
    push(1, "eq_ab2", S_EQL, 8'd1); tick();
    cc_mux = 2'b11; data_a = 8'h11;
    push(1, "hold1", S_EQL, 8'd1); tick();
    data_b = 8'h22;
    push(1, "hold2", S_EQL, 8'd1); tick();

    enable_count = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      push(1, $sformatf("lim_cont%0d", i), S_CONT, (i == 15) ? 8'd1 : 8'd0);
      push(1, $sformatf("lim_busy%0d", i), S_BUSY, 8'd1);
      tick();
    end
    push(1, "hit_exit_cont", S_CONT, 8'd0);
    push(1, "hit_exit_busy", S_BUSY, 8'd0);
    tick();
    enable_count = 1'b0;
    tick();

    enable_count = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      push(1, $sformatf("run1_cont%0d", i), S_CONT, 8'd0);
      tick();
    end
    enable_count = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push(1, $sformatf("gap_cont%0d", i), S_CONT, 8'd0);
      push(1, $sformatf("gap_busy%0d", i), S_BUSY, 8'd0);
      tick();
    end
    enable_count = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(1, $sformatf("run2_cont%0d", i), S_CONT, (i == 8) ? 8'd1 : 8'd0);
      tick();
    end
    enable_count = 1'b0;
    push(1, "run2_after", S_CONT, 8'd0);
    tick();

    ackout = 1'b1;
    tick();
    push(1, "ack_held", S_ACK, 8'd1);
    tick();
    ackout = 1'b0;
    tick();
    for (int k = 2; k <= 300; k++) begin
      ackout = 1'b1;
      if (k == 254 || k == 255 || k == 256 || k == 300)
        push(1, $sformatf("ack_k%0d", k), S_ACK, (k > 255) ? 8'hFF : 8'(k));
      tick();
      ackout = 1'b0;
      tick();
    end

    uscite = 2'b01;
    push(1, "usc1_cv", S_CV, 8'd1); push(1, "usc1_code", S_CODE, 8'd1); tick();
    push(1, "usc2_cv", S_CV, 8'd0); push(1, "usc2_code", S_CODE, 8'd1); tick();
    uscite = 2'b11;
    push(1, "usc3_cv", S_CV, 8'd1); push(1, "usc3_code", S_CODE, 8'd3); tick();
    push(1, "usc4_cv", S_CV, 8'd0); push(1, "usc4_code", S_CODE, 8'd3); tick();

    uscite = 2'b00;
    enable_count = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    push(0, "mid_busy", S_BUSY, 8'd1);
    drain();
    #2 reset = 1'b1;
    #1;
    push_all_reset("async");
    drain();
    tick();
    tick();
    reset = 1'b0;
    ackout = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      push(1, $sformatf("abort_cont%0d", i), S_CONT, (i == 15) ? 8'd1 : 8'd0);
      tick();
    end
    enable_count = 1'b0;
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    ackout = 1'b0;
    enable_count = 1'b1;
    for (int i = 1; i <= 16; i++) begin
`ifdef EQL_RESP_TIMEOUT_EN
      push(1, $sformatf("tmo%0d", i), S_TMO, (i == 16) ? 8'd1 : 8'd0);
`else
      push(1, $sformatf("tmo%0d", i), S_TMO, 8'd0);
`endif
      tick();
    end
    ackout = 1'b1;
    enable_count = 1'b0;
    for (int i = 1; i <= 3; i++) begin
`ifdef EQL_RESP_TIMEOUT_EN
      push(1, $sformatf("tmo_hold%0d", i), S_TMO, 8'd1);
`else
      push(1, $sformatf("tmo_hold%0d", i), S_TMO, 8'd0);
`endif
      tick();
    end

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
